lfsr_sequencer: RTL and testbench

- Controller that owns and sequences the 4-bit Galois LFSR (x^4+x+1) used across the exam datapaths.
- Accepts a seed and step count via start handshake; advances the LFSR that many cycles, with pause support; reports each new value, period wrap and completion.
- Sits between a host FSM/testbench and any consumer of the pseudo-random stream.

---
 rtl/lfsr_sequencer.sv | 141 ++++++++++++++
 tb/tb_lfsr_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : lfsr_sequencer
//  Purpose  : Owns and sequences a Galois LFSR (default x^4+x+1). A start
//             request in IDLE loads a seed and a step count. The LFSR then
//             advances once per un-held cycle until the count is used up.
//             Each new value is flagged, and so are period wrap and
//             completion.
//  Ports    : clk      - system clock, rising edge
//             reset    - synchronous, active-high reset
//             start    - run request, sampled only in IDLE
//             seed     - initial LFSR value, latched on accepted start
//             steps    - number of advances for the run
//             hold     - freezes LFSR and counter while in RUN
//             q        - current LFSR value (registered)
//             valid    - pulse: q holds a newly advanced value
//             wrap     - pulse with valid when q equals the latched seed
//             busy     - high while in RUN
//             done     - one-cycle pulse in DONE
//             seed_err - pulse the cycle after a zero seed was replaced
//  Options  : LFSR_ZERO_GUARD_EN - when defined, a zero seed is replaced by
//             1 and seed_err pulses; otherwise seed_err is tied low.
//  Revision : 1.0 - initial release
// ============================================================================
module lfsr_sequencer #(
    parameter int                 WIDTH = 4,
    parameter logic [WIDTH-1:0]   TAPS  = 'b0011,
    parameter int                 CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] seed,
    input  logic [CNT_W-1:0] steps,
    input  logic             hold,
    output logic [WIDTH-1:0] q,
    output logic             valid,
    output logic             wrap,
    output logic             busy,
    output logic             done,
    output logic             seed_err
);

    localparam logic [WIDTH-1:0] c_ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_seed;
    logic [CNT_W-1:0] r_remaining;
    logic             r_valid;
    logic             r_wrap;

    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_load_value;
    logic             w_accept;

    // Galois step: shift left and fold the taps back in when the MSB leaves.
    assign w_next   = {r_q[WIDTH-2:0], 1'b0} ^ (r_q[WIDTH-1] ? TAPS : '0);
    assign w_accept = (r_state == S_IDLE) && start;

`ifdef LFSR_ZERO_GUARD_EN
    logic w_seed_is_zero;
    logic r_seed_err;

    // An all-zero seed would lock the LFSR, so substitute the reset value.
    assign w_seed_is_zero = (seed == '0);
    assign w_load_value   = w_seed_is_zero ? c_ONE : seed;
    assign seed_err       = r_seed_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_seed_err <= 1'b0;
        end else begin
            r_seed_err <= w_accept && w_seed_is_zero;
        end
    end
`else
    assign w_load_value = seed;
    assign seed_err     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_q         <= c_ONE;
            r_seed      <= c_ONE;
            r_remaining <= '0;
            r_valid     <= 1'b0;
            r_wrap      <= 1'b0;
        end else begin
            // Pulses are cleared unless an advance happens this cycle.
            r_valid <= 1'b0;
            r_wrap  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_q         <= w_load_value;
                        r_seed      <= w_load_value;
                        r_remaining <= steps;
                        r_state     <= (steps == '0) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (!hold) begin
                        r_q         <= w_next;
                        r_valid     <= 1'b1;
                        r_wrap      <= (w_next == r_seed);
                        // Saturating decrement; RUN is never entered with zero.
                        if (r_remaining != '0) begin
                            r_remaining <= r_remaining - c_CNT_ONE;
                        end
                        if (r_remaining <= c_CNT_ONE) begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign q     = r_q;
    assign valid = r_valid;
    assign wrap  = r_wrap;
    assign busy  = (r_state == S_RUN);
    assign done  = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_lfsr_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lfsr_sequencer
//  Purpose  : Self-checking bench for lfsr_sequencer. Directed runs cover the
//             listed scenarios. Randomized runs then follow, with random
//             seeds, counts, hold, stray start/seed/steps changes and
//             occasional mid-run reset. All of it is compared cycle by cycle
//             with a reference model. That model walks the published
//             maximal-length sequence table instead of using shift/XOR
//             arithmetic.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lfsr_sequencer;

    logic       clk;
    logic       reset;
    logic       start;
    logic [3:0] seed;
    logic [7:0] steps;
    logic       hold;
    logic [3:0] q;
    logic       valid;
    logic       wrap;
    logic       busy;
    logic       done;
    logic       seed_err;

    int n_checks = 0;
    int n_errors = 0;

    lfsr_sequencer #(
        .WIDTH (4),
        .TAPS  (4'b0011),
        .CNT_W (8)
    ) u_dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .seed     (seed),
        .steps    (steps),
        .hold     (hold),
        .q        (q),
        .valid    (valid),
        .wrap     (wrap),
        .busy     (busy),
        .done     (done),
        .seed_err (seed_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int c_seq [15] = '{1, 2, 4, 8, 3, 6, 12, 11, 5, 10, 7, 14, 15, 13, 9};

    // Mode: 0 idle, 1 running, 2 finished.
    int       m_mode;
    int       m_rem;
    int       m_q;
    int       m_ref;
    bit       m_valid;
    bit       m_wrap;
    bit       m_err;

    function automatic int succ(input int v);
        succ = 0;
        for (int i = 0; i < 15; i++) begin
            if (c_seq[i] == v) succ = c_seq[(i + 1) % 15];
        end
    endfunction

    function automatic bit guard_on();
`ifdef LFSR_ZERO_GUARD_EN
        guard_on = 1'b1;
`else
        guard_on = 1'b0;
`endif
    endfunction

    task automatic model_reset();
        m_mode  = 0;
        m_rem   = 0;
        m_q     = 1;
        m_ref   = 1;
        m_valid = 0;
        m_wrap  = 0;
        m_err   = 0;
    endtask

    task automatic model_edge();
        bit nv, nw, ne;
        nv = 0; nw = 0; ne = 0;
        if (reset) begin
            model_reset();
            return;
        end
        if (m_mode == 2) begin
            m_mode = 0;
        end else if (m_mode == 1) begin
            if (!hold) begin
                m_q   = succ(m_q);
                nv    = 1;
                nw    = (m_q == m_ref);
                m_rem = m_rem - 1;
                if (m_rem == 0) m_mode = 2;
            end
        end else if (start) begin
            if (seed == 0 && guard_on()) begin
                m_q = 1;
                ne  = 1;
            end else begin
                m_q = int'(seed);
            end
            m_ref  = m_q;
            m_rem  = int'(steps);
            m_mode = (steps == 0) ? 2 : 1;
        end
        m_valid = nv;
        m_wrap  = nw;
        m_err   = ne;
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: model follows the edge, outputs compared 1 time unit later.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("q",        32'(q),        32'(m_q));
        check("valid",    32'(valid),    32'(m_valid));
        check("wrap",     32'(wrap),     32'(m_wrap));
        check("busy",     32'(busy),     32'(m_mode == 1));
        check("done",     32'(done),     32'(m_mode == 2));
        check("seed_err", 32'(seed_err), 32'(m_err));
    endtask

    task automatic launch(input logic [3:0] s, input logic [7:0] n);
        seed  = s;
        steps = n;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int nwrap;
        int budget;
        model_reset();
        reset = 1'b1;
        start = 1'b0;
        seed  = '0;
        steps = '0;
        hold  = 1'b0;

        // Reset held, then idle with start low.
        repeat (5) tick();
        check("rst_q", 32'(q), 32'h1);
        reset = 1'b0;
        repeat (3) tick();
        check("idle_q", 32'(q), 32'h1);

        // Four-step run from 0001.
        launch(4'b0001, 8'd4);
        repeat (4) tick();
        check("run4_q", 32'(q), 32'h3);
        check("run4_done", 32'(done), 32'h1);
        tick();
        check("run4_busy", 32'(busy), 32'h0);

        // Full period from 1000: single wrap, on the last step.
        launch(4'b1000, 8'd15);
        nwrap = 0;
        repeat (15) begin
            tick();
            if (wrap) nwrap++;
        end
        check("p15_wraps", 32'(nwrap), 32'h1);
        check("p15_q", 32'(q), 32'h8);
        check("p15_wrap_done", 32'({wrap, done}), 32'h3);
        tick();

        // Zero-step run goes straight to DONE.
        launch(4'b1011, 8'd0);
        check("zero_q", 32'(q), 32'hB);
        check("zero_done", 32'(done), 32'h1);
        check("zero_valid", 32'(valid), 32'h0);
        tick();

        // Hold after the second advance.
        launch(4'b0001, 8'd6);
        repeat (2) tick();
        hold = 1'b1;
        repeat (3) begin
            tick();
            check("hold_q", 32'(q), 32'h4);
        end
        hold = 1'b0;
        repeat (4) tick();
        check("hold_end", 32'({q, done}), 32'({4'hC, 1'b1}));
        tick();

        // Reset in the middle of a run.
        launch(4'b0101, 8'd20);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_q", 32'(q), 32'h1);
        check("midrst_busy", 32'(busy), 32'h0);
        tick();

        // Zero seed.
        launch(4'b0000, 8'd3);
        repeat (3) tick();
        check("zseed_q", 32'(q), guard_on() ? 32'h8 : 32'h0);
        tick();

        // Randomized runs.
        for (int r = 0; r < 40; r++) begin
            launch(4'($urandom), 8'($urandom_range(0, 35)));
            budget = 400;
            while (m_mode != 0 && budget > 0) begin
                hold  = ($urandom_range(0, 3) == 0);
                start = 1'($urandom);
                seed  = 4'($urandom);
                steps = 8'($urandom);
                reset = ($urandom_range(0, 150) == 0);
                tick();
                reset = 1'b0;
                budget--;
            end
            check("run_budget", 32'(budget > 0), 32'h1);
            hold  = 1'($urandom);
            start = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
            hold = 1'b0;
        end

        // Maximum count.
        launch(4'($urandom), 8'd255);
        repeat (255) tick();
        check("max_done", 32'(done), 32'h1);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
